// File: rtl/aes128_enc_unrolled.sv
// AES-128 encryption core computing UNROLL rounds per clock with an on-the-fly key schedule,
// optional random dummy cycles and the SASEBO-GIII Krdy/Drdy/Kvld/Dvld/BSY handshake.
module aes128_enc_unrolled #(
  parameter int UNROLL    = 1,
  parameter int MAX_DUMMY = 0,
  parameter int RND_W     = 4
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             EN,
  input  logic [127:0]     Kin,
  input  logic             Krdy,
  input  logic [127:0]     Din,
  input  logic             Drdy,
  input  logic             DLY_EN,
  input  logic [RND_W-1:0] RND,
  output logic [127:0]     Dout,
  output logic             Kvld,
  output logic             Dvld,
  output logic             BSY
);

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 5 || UNROLL == 10)) begin : g_bad_unroll
    $fatal(1, "aes128_enc_unrolled: UNROLL must be 1, 2, 5 or 10");
  end
  if (MAX_DUMMY < 0 || MAX_DUMMY > 15) begin : g_bad_dummy
    $fatal(1, "aes128_enc_unrolled: MAX_DUMMY must be in 0..15");
  end
  if (RND_W < 1) begin : g_bad_rnd
    $fatal(1, "aes128_enc_unrolled: RND_W must be at least 1");
  end

  localparam logic [3:0] LAST_IDX = 4'(11 - UNROLL);
  localparam logic [3:0] MAX_D    = 4'(MAX_DUMMY);

  typedef enum logic {IDLE, RUN} state_t;

  state_t       state;
  logic [127:0] krg, krgx, drg;
  logic [127:0] rk_chain, st_chain;
  logic [3:0]   round_idx, dummy_cnt;
  logic         dummy, last_step;
  logic         unused_inputs;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box: multiplicative inverse as x^254, then the affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq, inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input int rnd);
    case (rnd)
      1:       return 8'h01;
      2:       return 8'h02;
      3:       return 8'h04;
      4:       return 8'h08;
      5:       return 8'h10;
      6:       return 8'h20;
      7:       return 8'h40;
      8:       return 8'h80;
      9:       return 8'h1b;
      10:      return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] next_key(input logic [127:0] k, input int rnd);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = k;
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rcon(rnd), 24'h0};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // SubBytes and ShiftRows fused; byte 4*c+r sits at the MSB end of the block
  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                             input logic last);
    logic [7:0]   b [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        b[4*c+r] = sbox(s[127-8*(4*((c+r)%4)+r) -: 8]);
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = b[4*c];
      a1 = b[4*c+1];
      a2 = b[4*c+2];
      a3 = b[4*c+3];
      if (last)
        o[127-32*c -: 32] = {a0, a1, a2, a3};
      else
        o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                             a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                             a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                             xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return o ^ rk;
  endfunction

  // Chain UNROLL rounds, each deriving its round key from the previous one
  always_comb begin
    rk_chain = krgx;
    st_chain = drg;
    for (int u = 0; u < UNROLL; u++) begin
      rk_chain = next_key(rk_chain, int'(round_idx) + u);
      st_chain = aes_round(st_chain, rk_chain, (int'(round_idx) + u) == 10);
    end
  end

  assign dummy         = (MAX_DUMMY > 0) && DLY_EN && RND[0] && (dummy_cnt < MAX_D);
  assign last_step     = (round_idx == LAST_IDX);
  assign unused_inputs = ^{DLY_EN, RND};

  // Completion restores the working key so the next block starts from the cipher key
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state     <= IDLE;
      krg       <= '0;
      krgx      <= '0;
      drg       <= '0;
      Dout      <= '0;
      round_idx <= '0;
      dummy_cnt <= '0;
      Kvld      <= 1'b0;
      Dvld      <= 1'b0;
      BSY       <= 1'b0;
    end else if (EN) begin
      Kvld <= 1'b0;
      Dvld <= 1'b0;
      case (state)
        IDLE: begin
          if (Krdy) begin
            krg  <= Kin;
            krgx <= Kin;
            Kvld <= 1'b1;
          end else if (Drdy) begin
            drg       <= Din ^ krg;
            round_idx <= 4'd1;
            dummy_cnt <= '0;
            BSY       <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          if (dummy) begin
            dummy_cnt <= dummy_cnt + 4'd1;
          end else if (last_step) begin
            Dout      <= st_chain;
            Dvld      <= 1'b1;
            BSY       <= 1'b0;
            krgx      <= krg;
            round_idx <= '0;
            state     <= IDLE;
          end else begin
            drg       <= st_chain;
            krgx      <= rk_chain;
            round_idx <= round_idx + 4'(UNROLL);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/aes128_enc_unrolled.md
Name: aes128_enc_unrolled

Overview:
Parametrised AES-128 encryption engine that completes UNROLL rounds per clock (UNROLL in 1, 2, 5, 10). The key schedule runs on the fly and restores the cipher key after every block. An optional random dummy-cycle insertion hides round timing. It drops into the SASEBO-GIII AES wrapper alongside the existing single-round iterative core, using the same Krdy/Drdy/Kvld/Dvld/BSY handshake.

Parameters:
UNROLL, 1, rounds computed per clock; legal values 1, 2, 5, 10; any other value is a fatal elaboration error.
MAX_DUMMY, 0, maximum dummy (stall) cycles inserted per block; 0 removes the delay logic; range 0..15.
RND_W, 4, width of the random input used for dummy decisions; minimum 1.

Ports:
CLK  in  1  system clock, rising edge
RSTn  in  1  asynchronous active-low reset
EN  in  1  core enable; when 0, all registers hold
Kin  in  128  cipher key
Krdy  in  1  key load strobe
Din  in  128  plaintext
Drdy  in  1  plaintext start strobe
DLY_EN  in  1  enables dummy-cycle insertion (ignored if MAX_DUMMY=0)
RND  in  RND_W  fresh random bits, one word sampled each cycle
Dout  out  128  ciphertext; held until the next completion
Kvld  out  1  one-cycle pulse after key load
Dvld  out  1  one-cycle pulse when Dout is updated
BSY  out  1  high while a block is in progress

Behaviour:
- Reset (RSTn=0, asynchronous): Krg, KrgX, Drg, Dout = 0; round index = 0; dummy count = 0; Kvld = Dvld = BSY = 0; FSM = IDLE. Reset mid-block aborts the block; no Dvld is issued.
- EN=0: all state freezes, including FSM, counters and pulse outputs. Pulses remain high if frozen high.
- FSM states: IDLE, RUN.
- IDLE, Krdy=1:
  - Krg <= Kin; KrgX <= Kin; Kvld=1 for the next cycle.
  - Krdy has priority over a simultaneous Drdy; that Drdy is dropped.
- IDLE, Drdy=1 (Krdy=0):
  - Drg <= Din ^ Krg; round index <= 1; dummy count <= 0; BSY <= 1; go to RUN.
- RUN, per cycle:
  - Dummy condition: DLY_EN=1 AND RND[0]=1 AND dummy count < MAX_DUMMY.
  - If the dummy condition holds: Drg, KrgX and round index hold; dummy count increments.
  - Otherwise: apply UNROLL chained rounds to Drg, using round keys r .. r+UNROLL-1 derived combinationally from KrgX.
  - Round 10 omits MixColumns.
  - Round index advances by UNROLL. KrgX <= last derived round key.
- Rcon: derived from the absolute round number (01, 02, 04, 08, 10, 20, 40, 80, 1b, 36), not from a rotating one-hot register.
- Completion: when the round that includes round 10 is applied:
  - Dout <= result; Dvld=1 next cycle; BSY <= 0; KrgX <= Krg; FSM = IDLE.
- Latency:
  - With no dummies: Drdy at edge e0, result at edge e(10/UNROLL); Dvld high in the cycle after that edge.
  - Total latency = 10/UNROLL + 1 edges + inserted dummies.
  - Dummies per block are at most MAX_DUMMY.
- Krdy/Drdy during RUN: ignored; not queued.
- Drdy may be asserted in the same cycle Dvld is high; the block starts normally (back-to-back throughput).
- Dout is never zeroed between blocks; it changes only at completion or reset.
- A new key loaded after a block leaves Dout unchanged.

Test Plan:
- FIPS-197 C.1, UNROLL=1, MAX_DUMMY=0: Kin=000102..0f, Krdy pulse, then Din=00112233445566778899aabbccddeeff. Required: Dout=69c4e0d86a7b0430d8cdb78070b4c55a; Dvld exactly 11 edges after Drdy; BSY high 10 cycles.
- Appendix B vector for UNROLL=2, 5, 10: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734. Required: Dout=3925841d02dc09fbdc118597196a0b32 with latency 6, 3 and 2 edges respectively.
- Dummy insertion, UNROLL=1, MAX_DUMMY=4, DLY_EN=1, RND[0] held at 1. Required: same ciphertext; latency exactly 15 edges; with RND[0]=0, latency 11.
- Back-to-back blocks: Drdy reasserted in the Dvld cycle with a second plaintext. Required: both ciphertexts correct; KrgX restored (second result matches its standalone result).
- Simultaneous Krdy and Drdy in IDLE: key loads, Kvld pulses, no block starts (BSY stays 0). Krdy during RUN does not alter the running result.
- Reset mid-operation: RSTn low asynchronously at round 5. Required: all outputs 0 immediately; no Dvld; a following block runs correctly. EN low for 3 cycles mid-block stretches latency by exactly 3.
